aes_block_assembler: RTL and testbench

- Upstream feeder for the AES core's plaintext input (`plain[127:0]`).
- Accepts an 8-bit byte stream from the bus-side write path with valid/ready flow control and packs 16 bytes into one 128-bit block.
- Holds each finished block in a one-entry output slot and hands it to the core with a valid/ready handshake.
- A short final block is zero-padded. Assembly of the next block overlaps with the core draining the current one.

---
 rtl/aes_stream_pkg.sv | 8 +
 rtl/aes_block_assembler_if.sv | 20 ++
 rtl/aes_blk_slot.sv | 37 +++
 rtl/aes_block_assembler.sv | 63 ++++++
 tb/tb_aes_block_assembler.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/aes_stream_pkg.sv
// aes_stream_pkg: shared block geometry and types for the AES plaintext/ciphertext stream path
package aes_stream_pkg;
  localparam int AES_BLK_BYTES = 16;
  localparam int AES_BLK_W = 8 * AES_BLK_BYTES;
  localparam int AES_CNT_W = $clog2(AES_BLK_BYTES) + 1;
  typedef logic [AES_BLK_W-1:0] aes_blk_t;
  typedef logic [AES_CNT_W-1:0] pad_cnt_t;
endpackage

// File: rtl/aes_block_assembler_if.sv
// aes_block_assembler_if: byte-stream and block handshake bundles
interface aes_byte_if;
  logic       valid;
  logic       ready;
  logic       last;
  logic [7:0] data;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

interface aes_blk_if;
  import aes_stream_pkg::*;
  aes_blk_t blk;
  logic     valid;
  logic     ready;
  logic     last;
  pad_cnt_t pad;
  modport master (output blk, valid, last, pad, input ready);
  modport slave (input blk, valid, last, pad, output ready);
endinterface

// File: rtl/aes_blk_slot.sv
// aes_blk_slot: one-entry block holding register with valid/ready output handshake
module aes_blk_slot
  import aes_stream_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_clr,
  input  logic      i_load,
  input  aes_blk_t  i_blk,
  input  logic      i_last,
  input  pad_cnt_t  i_pad,
  aes_blk_if.master o_blk,
  output logic      o_consume
);
  assign o_consume = o_blk.valid && o_blk.ready;
  // Loads only arrive when the slot is empty or draining, so the held block is stable under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_blk.valid <= 1'b0;
      o_blk.blk   <= '0;
      o_blk.last  <= 1'b0;
      o_blk.pad   <= '0;
    end else if (i_clr) begin
      o_blk.valid <= 1'b0;
      o_blk.blk   <= '0;
      o_blk.last  <= 1'b0;
      o_blk.pad   <= '0;
    end else if (i_load) begin
      o_blk.valid <= 1'b1;
      o_blk.blk   <= i_blk;
      o_blk.last  <= i_last;
      o_blk.pad   <= i_pad;
    end else if (o_consume) begin
      o_blk.valid <= 1'b0;
    end
  end
endmodule

// File: rtl/aes_block_assembler.sv
// aes_block_assembler: packs an MSB-first byte stream into zero-padded 128-bit AES plaintext blocks
module aes_block_assembler
  import aes_stream_pkg::*;
#(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  aes_byte_if.slave            i_in,
  aes_blk_if.master            o_out,
  output logic [BLK_CNT_W-1:0] o_blk_count
);
  aes_blk_t r_asm, w_asm_nxt;
  pad_cnt_t r_cnt, r_pad, w_cnt_nxt;
  logic     r_asm_full, r_last, w_xfer, w_acc, w_close, w_consume;
  assign w_xfer     = r_asm_full && (!o_out.valid || o_out.ready);
  assign i_in.ready = rst_n && !i_clr && (!r_asm_full || w_xfer);
  assign w_acc      = i_in.valid && i_in.ready;
  assign w_cnt_nxt  = r_cnt + pad_cnt_t'(1);
  assign w_close    = w_acc && (w_cnt_nxt == pad_cnt_t'(AES_BLK_BYTES) || i_in.last);
  // A byte taken in the hand-off cycle becomes byte 0 of the freshly cleared register
  assign w_asm_nxt  = (w_xfer ? '0 : r_asm)
                    | (w_acc ? aes_blk_t'(i_in.data) << (8 * (AES_BLK_BYTES - 1 - int'(r_cnt))) : '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm      <= '0;
      r_cnt      <= '0;
      r_pad      <= '0;
      r_last     <= 1'b0;
      r_asm_full <= 1'b0;
    end else if (i_clr) begin
      r_asm      <= '0;
      r_cnt      <= '0;
      r_pad      <= '0;
      r_last     <= 1'b0;
      r_asm_full <= 1'b0;
    end else begin
      r_asm      <= w_asm_nxt;
      r_cnt      <= w_close ? '0 : w_acc ? w_cnt_nxt : r_cnt;
      r_asm_full <= w_close || (r_asm_full && !w_xfer);
      if (w_close) begin
        r_pad  <= pad_cnt_t'(AES_BLK_BYTES) - w_cnt_nxt;
        r_last <= i_in.last;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_blk_count <= '0;
    else if (w_consume) o_blk_count <= o_blk_count + BLK_CNT_W'(1);
  end
  aes_blk_slot u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (i_clr),
    .i_load    (w_xfer),
    .i_blk     (r_asm),
    .i_last    (r_last),
    .i_pad     (r_pad),
    .o_blk     (o_out),
    .o_consume (w_consume)
  );
endmodule

// File: tb/tb_aes_block_assembler.sv
// tb_aes_block_assembler: random and directed byte streams checked against a queue-based block model
module tb_aes_block_assembler;
  import aes_stream_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [15:0] blk_count;
  int n_chk = 0, n_err = 0, m_cnt = 0, cyc = 0, c0;
  aes_byte_if u_in ();
  aes_blk_if  u_out ();
  aes_block_assembler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (clr),
    .i_in        (u_in),
    .o_out       (u_out),
    .o_blk_count (blk_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  typedef struct {
    logic [127:0] b;
    logic         l;
    logic [4:0]   p;
    logic         v;
  } ent_t;
  ent_t q[$];
  logic [7:0] part[$];
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Model: completed blocks wait in q; the oldest becomes visible one edge after it completes
  always @(negedge clk) begin
    logic rdy_e, val_e;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      part.delete();
      m_cnt = 0;
    end
    rdy_e = rst_n && !clr && (q.size() < 2 || u_out.ready);
    val_e = q.size() > 0 && q[0].v;
    chk("in_ready", u_in.ready, rdy_e);
    chk("plain_valid", u_out.valid, val_e);
    chk("blk_count", blk_count, m_cnt);
    if (val_e) begin
      chk("plain", u_out.blk, q[0].b);
      chk("plain_last", u_out.last, q[0].l);
      chk("plain_pad", u_out.pad, q[0].p);
    end
    if (rst_n) begin
      if (val_e && u_out.ready) begin
        m_cnt++;
        void'(q.pop_front());
      end
      if (clr) begin
        q.delete();
        part.delete();
      end else begin
        if (q.size() > 0 && !q[0].v) q[0].v = 1'b1;
        if (u_in.valid && rdy_e) begin
          part.push_back(u_in.data);
          if (part.size() == 16 || u_in.last) begin
            e.b = '0;
            foreach (part[k]) e.b[127-8*k -: 8] = part[k];
            e.l = u_in.last;
            e.p = 5'(16 - part.size());
            e.v = 1'b0;
            q.push_back(e);
            part.delete();
          end
        end
      end
    end
  end
  task automatic send(input logic [7:0] d, input logic l);
    bit acc = 0;
    u_in.valid = 1'b1;
    u_in.data  = d;
    u_in.last  = l;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = u_in.ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    u_in.valid = 1'b0;
    u_in.last  = 1'b0;
  endtask
  initial begin
    u_in.valid = 1'b0;
    u_in.data  = '0;
    u_in.last  = 1'b0;
    u_out.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", u_in.ready, 0);
    chk("rst_plain", u_out.blk, 0);
    chk("rst_pad", u_out.pad, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", u_in.ready, 1);
    @(posedge clk);
    #1;
    u_out.ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    chk("t1_lat", u_out.valid, 0);
    @(posedge clk);
    #1;
    chk("t1_valid", u_out.valid, 1);
    chk("t1_plain", u_out.blk, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_pad", u_out.pad, 0);
    chk("t1_last", u_out.last, 0);
    @(posedge clk);
    #1;
    chk("t1_count", blk_count, 1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    chk("t2_lat", u_out.valid, 0);
    @(posedge clk);
    #1;
    chk("t2_plain", u_out.blk, 128'hAABBCC00_00000000_00000000_00000000);
    chk("t2_pad", u_out.pad, 13);
    chk("t2_last", u_out.last, 1);
    @(posedge clk);
    #1;
    chk("t2_count", blk_count, 2);
    c0 = cyc;
    repeat (48) send(8'($urandom), 1'b0);
    chk("t3_cycles", cyc - c0, 48);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_count", blk_count, 5);
    u_out.ready = 1'b0;
    repeat (32) send(8'($urandom), 1'b0);
    u_in.valid = 1'b1;
    u_in.data  = 8'h5A;
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall", u_in.ready, 0);
    end
    @(posedge clk);
    #1;
    chk("t4_held", blk_count, 5);
    u_out.ready = 1'b1;
    send(8'h5A, 1'b0);
    repeat (7) send(8'($urandom), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_count", blk_count, 7);
    chk("t4_drained", u_out.valid, 0);
    repeat (7) send(8'($urandom), 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("t5_clr_count", blk_count, 7);
    for (int i = 0; i < 16; i++) send(8'(8'h30 + i), 1'b0);
    @(posedge clk);
    #1;
    chk("t5_plain", u_out.blk, 128'h303132333435363738393A3B3C3D3E3F);
    @(posedge clk);
    #1;
    chk("t5_count", blk_count, 8);
    u_out.ready = 1'b0;
    repeat (21) send(8'($urandom), 1'b0);
    chk("t6_pre_valid", u_out.valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", u_out.valid, 0);
    chk("t6_plain", u_out.blk, 0);
    chk("t6_last", u_out.last, 0);
    chk("t6_pad", u_out.pad, 0);
    chk("t6_count", blk_count, 0);
    chk("t6_in_ready", u_in.ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    u_out.ready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
    @(posedge clk);
    #1;
    chk("t6_plain_new", u_out.blk, 128'h404142434445464748494A4B4C4D4E4F);
    @(posedge clk);
    #1;
    chk("t6_count_new", blk_count, 1);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
